decode_issue_ctrl: RTL
======================

Name: decode_issue_ctrl

Overview:
- Decode/issue stage controller sitting between instruction fetch and execute, and the single owner of the decode instruction register.
- Accepts instructions from fetch with a valid/ready handshake and holds the current instruction in the decode register.
- Drives the decode register onto the immediate generator together with its format select, plus the main control signals.
- Detects load-use hazards and inserts one bubble per hazard, honours branch flush from execute, and halts on an illegal opcode.

Parameters:
- INSTR_WIDTH, 32, instruction width; opcode fields are fixed at RV32 bit positions.
- REG_ADDR_WIDTH, 5, register index width.
- CNT_WIDTH, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- if_instr  in  INSTR_WIDTH  instruction from fetch.
- if_valid  in  1  if_instr is valid.
- if_ready  out  1  decode can accept if_instr this cycle.
- ex_ready  in  1  execute accepts the decode output, or a bubble, this cycle.
- ex_flush  in  1  branch taken in execute; kill decode contents.
- id_instr  out  INSTR_WIDTH  decode register contents; feeds the immediate generator.
- id_valid  out  1  id_instr and the controls are valid for issue.
- id_imm_sel  out  2  immediate format: 0 = I (load / op-imm), 1 = S, 2 = B, 3 = none.
- id_rs1, id_rs2, id_rd  out  REG_ADDR_WIDTH each  register fields; id_rd is 0 for store and branch.
- id_mem_rd, id_mem_wr, id_reg_wr, id_branch, id_alu_imm  out  1 each  control signals.
- illegal  out  1  sticky illegal-opcode flag.
- stall_cnt, issue_cnt  out  CNT_WIDTH each  saturating counts of bubbles and issued instructions.

Behaviour:

Decode of opcode bits [6:0]:

| Opcode | Class | id_imm_sel | Controls asserted |
|---|---|---|---|
| 0000011 | load | 0 | mem_rd, reg_wr, alu_imm |
| 0010011 | op-imm | 0 | reg_wr, alu_imm |
| 0100011 | store | 1 | mem_wr, alu_imm |
| 1100011 | branch | 2 | branch |
| 0110011 | op | 3 | reg_wr |
| anything else | illegal | — | — |

- rs1 is used by every class; rs2 is used by store, branch and op only.
- Control outputs are combinational from the decode register, and are 0 whenever d_valid = 0.

State:
- Registers: d_instr, d_valid, ex_load (EX holds a load), ex_rd, and FSM state ∈ {RUN, HALT}.
- Reset: state = RUN, d_valid = 0, d_instr = 0, ex_load = 0, ex_rd = 0, illegal = 0, both counters = 0.
- Consequently all outputs are 0 after reset, including if_ready during the reset cycle, and id_imm_sel = 3 after reset.

Hazard and issue:
- hazard = d_valid & ex_load & (ex_rd != 0) & ((rs1 == ex_rd) | (uses_rs2 & rs2 == ex_rd)).
- id_valid = (state == RUN) & d_valid & ~hazard & legal & ~ex_flush.
- issue = id_valid & ex_ready. On issue: ex_load <= is_load and ex_rd <= rd; issue_cnt increments.
- bubble = (state == RUN) & hazard & ex_ready & ~ex_flush. On bubble: ex_load <= 0 and stall_cnt increments.
- If ex_ready = 0, the ex_load and ex_rd records hold.
- Every load-use hazard costs exactly one bubble cycle when ex_ready = 1.

Fetch handshake:
- if_ready = (state == RUN) & ~ex_flush & (~d_valid | issue).
- Accept when if_valid & if_ready: d_instr <= if_instr and d_valid <= 1.
- Issue without a new accept sets d_valid <= 0.
- d_instr holds while d_valid = 1 and there is no issue; it never changes under backpressure.

Flush:
- ex_flush has priority over accept, issue and bubble.
- That cycle: d_valid <= 0, ex_load <= 0, id_valid = 0, if_ready = 0, and no counter increments.

Illegal opcode:
- Condition: state = RUN, d_valid = 1, opcode not in the decode list, and ex_flush = 0.
- Response: illegal <= 1 and state <= HALT; id_valid stays 0 for that instruction.
- HALT: if_ready = 0 and id_valid = 0. ex_flush still clears d_valid, but state stays HALT until reset.

Counters:
- Both counters saturate at all-ones and do not wrap.

Reset mid-operation:
- Reset in any state returns every register to its reset value on the next edge.
- Any in-flight instruction is discarded.

Test Plan:
- Reset, then stream 0x00000013 (nop), if_valid = 1, ex_ready = 1 -> if_ready = 1, id_valid = 1 every cycle from the 2nd cycle, id_imm_sel = 0, issue_cnt increments by 1 per cycle.
- Issue lw x5,0(x1) = 0x0000A283, then add x6,x5,x2 = 0x00228333 -> id_valid = 0 for exactly one cycle while the add is in decode, stall_cnt = 1; the add then issues with id_rs1 = 5, id_rs2 = 2, id_rd = 6, id_imm_sel = 3.
- Issue lw x0,... = 0x00002003, followed by an instruction reading x0 -> no bubble, stall_cnt = 0.
- Hold ex_ready = 0 for 3 cycles with a valid sw 0x0050A223 in decode -> if_ready = 0, id_instr stable, id_imm_sel = 1, id_mem_wr = 1, id_rd = 0; the sw issues on the cycle ex_ready returns to 1.
- Assert ex_flush in the same cycle as a hazard and if_valid -> id_valid = 0, if_ready = 0, stall_cnt unchanged; the next cycle d_valid = 0 and if_ready = 1.
- Feed 0x0000007F -> illegal = 1 and if_ready = 0 permanently; further if_valid is ignored and ex_flush does not clear the halt; reset clears illegal to 0.

Source files
------------

// File: rtl/decode_issue_ctrl_if.sv
// Fetch, execute and decode-output signals of the decode/issue controller.
// The slave modport is the controller; the master modport is its environment.
interface decode_issue_ctrl_if #(
   parameter int unsigned InstrWidth   = 32,
   parameter int unsigned RegAddrWidth = 5,
   parameter int unsigned CntWidth     = 16
);
   logic [InstrWidth-1:0]   if_instr;
   logic                    if_valid;
   logic                    if_ready;
   logic                    ex_ready;
   logic                    ex_flush;
   logic [InstrWidth-1:0]   id_instr;
   logic                    id_valid;
   logic [1:0]              id_imm_sel;
   logic [RegAddrWidth-1:0] id_rs1;
   logic [RegAddrWidth-1:0] id_rs2;
   logic [RegAddrWidth-1:0] id_rd;
   logic                    id_mem_rd;
   logic                    id_mem_wr;
   logic                    id_reg_wr;
   logic                    id_branch;
   logic                    id_alu_imm;
   logic                    illegal;
   logic [CntWidth-1:0]     stall_cnt;
   logic [CntWidth-1:0]     issue_cnt;

   modport master (
      output if_instr, if_valid, ex_ready, ex_flush,
      input  if_ready, id_instr, id_valid, id_imm_sel, id_rs1, id_rs2, id_rd,
             id_mem_rd, id_mem_wr, id_reg_wr, id_branch, id_alu_imm,
             illegal, stall_cnt, issue_cnt
   );

   modport slave (
      input  if_instr, if_valid, ex_ready, ex_flush,
      output if_ready, id_instr, id_valid, id_imm_sel, id_rs1, id_rs2, id_rd,
             id_mem_rd, id_mem_wr, id_reg_wr, id_branch, id_alu_imm,
             illegal, stall_cnt, issue_cnt
   );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller: owns the decode register, decodes RV32 opcodes,
// inserts one bubble per load-use hazard, honours flush and halts on illegal opcodes.
module decode_issue_ctrl #(
   parameter int unsigned InstrWidth   = 32,
   parameter int unsigned RegAddrWidth = 5,
   parameter int unsigned CntWidth     = 16
) (
   input logic                clk,
   input logic                reset,
   decode_issue_ctrl_if.slave bus
);

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpReg    = 7'b0110011;

   state_e                  state_q, state_d;
   logic [InstrWidth-1:0]   d_instr_q, d_instr_d;
   logic                    d_valid_q, d_valid_d;
   logic                    ex_load_q, ex_load_d;
   logic [RegAddrWidth-1:0] ex_rd_q, ex_rd_d;
   logic                    illegal_q, illegal_d;
   logic [CntWidth-1:0]     stall_cnt_q, stall_cnt_d;
   logic [CntWidth-1:0]     issue_cnt_q, issue_cnt_d;

   logic [6:0]              opcode;
   logic [RegAddrWidth-1:0] rs1, rs2, rd_field, rd;
   logic                    legal, is_load, uses_rs2, rd_used;
   logic                    mem_rd, mem_wr, reg_wr, branch, alu_imm;
   logic [1:0]              imm_sel;
   logic                    run, hazard, id_valid, issue, bubble, if_ready, accept, illegal_det;

   assign opcode   = d_instr_q[6:0];
   assign rs1      = d_instr_q[15 +: RegAddrWidth];
   assign rs2      = d_instr_q[20 +: RegAddrWidth];
   assign rd_field = d_instr_q[7 +: RegAddrWidth];

   always_comb begin
      legal    = 1'b0;
      is_load  = 1'b0;
      uses_rs2 = 1'b0;
      rd_used  = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      reg_wr   = 1'b0;
      branch   = 1'b0;
      alu_imm  = 1'b0;
      imm_sel  = 2'd3;
      case (opcode)
         OpLoad: begin
            legal   = 1'b1;
            is_load = 1'b1;
            rd_used = 1'b1;
            mem_rd  = 1'b1;
            reg_wr  = 1'b1;
            alu_imm = 1'b1;
            imm_sel = 2'd0;
         end
         OpImm: begin
            legal   = 1'b1;
            rd_used = 1'b1;
            reg_wr  = 1'b1;
            alu_imm = 1'b1;
            imm_sel = 2'd0;
         end
         OpStore: begin
            legal    = 1'b1;
            uses_rs2 = 1'b1;
            mem_wr   = 1'b1;
            alu_imm  = 1'b1;
            imm_sel  = 2'd1;
         end
         OpBranch: begin
            legal    = 1'b1;
            uses_rs2 = 1'b1;
            branch   = 1'b1;
            imm_sel  = 2'd2;
         end
         OpReg: begin
            legal    = 1'b1;
            uses_rs2 = 1'b1;
            rd_used  = 1'b1;
            reg_wr   = 1'b1;
         end
         default: ;
      endcase
   end

   assign rd = rd_used ? rd_field : '0;

   // Reset gates the handshakes so nothing is offered or accepted during the reset cycle.
   assign run         = (state_q == StRun) & ~reset;
   assign hazard      = d_valid_q & ex_load_q & (ex_rd_q != '0) &
                        ((rs1 == ex_rd_q) | (uses_rs2 & (rs2 == ex_rd_q)));
   assign id_valid    = run & d_valid_q & ~hazard & legal & ~bus.ex_flush;
   assign issue       = id_valid & bus.ex_ready;
   assign bubble      = run & hazard & bus.ex_ready & ~bus.ex_flush;
   assign if_ready    = run & ~bus.ex_flush & (~d_valid_q | issue);
   assign accept      = bus.if_valid & if_ready;
   assign illegal_det = run & d_valid_q & ~legal & ~bus.ex_flush;

   always_comb begin
      state_d     = state_q;
      d_instr_d   = d_instr_q;
      d_valid_d   = d_valid_q;
      ex_load_d   = ex_load_q;
      ex_rd_d     = ex_rd_q;
      illegal_d   = illegal_q;
      stall_cnt_d = stall_cnt_q;
      issue_cnt_d = issue_cnt_q;
      if (bus.ex_flush) begin
         d_valid_d = 1'b0;
         ex_load_d = 1'b0;
      end else begin
         if (accept) begin
            d_instr_d = bus.if_instr;
            d_valid_d = 1'b1;
         end else if (issue) begin
            d_valid_d = 1'b0;
         end
         if (issue) begin
            ex_load_d = is_load;
            ex_rd_d   = rd;
            if (issue_cnt_q != '1) issue_cnt_d = issue_cnt_q + CntWidth'(1);
         end
         if (bubble) begin
            ex_load_d = 1'b0;
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CntWidth'(1);
         end
         if (illegal_det) begin
            illegal_d = 1'b1;
            state_d   = StHalt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StRun;
         d_instr_q   <= '0;
         d_valid_q   <= 1'b0;
         ex_load_q   <= 1'b0;
         ex_rd_q     <= '0;
         illegal_q   <= 1'b0;
         stall_cnt_q <= '0;
         issue_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         d_instr_q   <= d_instr_d;
         d_valid_q   <= d_valid_d;
         ex_load_q   <= ex_load_d;
         ex_rd_q     <= ex_rd_d;
         illegal_q   <= illegal_d;
         stall_cnt_q <= stall_cnt_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

   assign bus.if_ready   = if_ready;
   assign bus.id_instr   = d_instr_q;
   assign bus.id_valid   = id_valid;
   assign bus.id_imm_sel = d_valid_q ? imm_sel : 2'd3;
   assign bus.id_rs1     = rs1;
   assign bus.id_rs2     = rs2;
   assign bus.id_rd      = rd;
   assign bus.id_mem_rd  = d_valid_q & mem_rd;
   assign bus.id_mem_wr  = d_valid_q & mem_wr;
   assign bus.id_reg_wr  = d_valid_q & reg_wr;
   assign bus.id_branch  = d_valid_q & branch;
   assign bus.id_alu_imm = d_valid_q & alu_imm;
   assign bus.illegal    = illegal_q;
   assign bus.stall_cnt  = stall_cnt_q;
   assign bus.issue_cnt  = issue_cnt_q;

endmodule
